tone_detector: RTL and testbench
================================

# tone_detector

Receive-side counterpart of the square-wave speaker tone generator. Measures the half-period of a 1-bit square wave on a GPIO input (comparator-squared microphone, or the generator's speaker pin looped back) and decodes it to one of the 12 chromatic note indices used by the generator. A sequential table-scan FSM does the decoding. A note is reported only after several consecutive matching half-periods. Sits between the GPIO pad and the note display/LED logic.

## Interface
- MAX_HALF, 200000: half-period saturation in cycles; reaching it means silence (timeout).
- MIN_HALF, 20000: shortest accepted half-period; shorter captures are glitches. Must be > 14.
- STABLE_COUNT, 4: consecutive matching half-periods required to assert a note. Range 1..15.
- SYNC_STAGES, 2: input synchronizer depth, ≥2.
- CLK_50  in  1  system clock, 50 MHz; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- TONE_IN  in  1  asynchronous square-wave input.
- ENABLE  in  1  1 = detect; 0 = hold everything in the reset state except the synchronizer.
- NOTE  out  4  note index: 0=A, 1=A#, 2=B, 3=C … 11=G#. Reset value 0.
- NOTE_VALID  out  1  NOTE is confirmed. Reset value 0.
- NOTE_STROBE  out  1  one-cycle pulse when NOTE_VALID rises or NOTE changes while valid. Reset value 0.
- HALF_PERIOD  out  18  last captured half-period in cycles. Reset value 0.

## Operation
- TONE_IN passes through SYNC_STAGES flops, then a registered edge detector. Both rising and falling edges count; a detected edge is an edge pulse.
- A free counter increments every cycle and saturates at MAX_HALF. On an edge pulse it restarts.
- Captured value = cycle distance between consecutive edge pulses. A generator with constant N produces N+1.
- The first edge after reset, timeout or disable only arms the capture; no value is captured.
- Nominal table, NOM[i] = generator constant + 1: 56819, 53659, 50608, 95420, 91912, 85035, 80386, 75758, 71633, 67568, 63756, 60241.
- Tolerance: a capture matches entry i when |cap − NOM[i]| ≤ NOM[i]>>6. The tolerance windows are disjoint.
- FSM states:
  - IDLE: waits for a capture. A capture below MIN_HALF is a glitch: clear the match counter and NOTE_VALID, and stay in IDLE. Otherwise go to SCAN.
  - SCAN: compares one table entry per cycle, index 0..11, and records the first hit. After 12 cycles go to DECIDE.
  - DECIDE:
    - Hit equals the candidate: increment the match counter, saturating at STABLE_COUNT.
    - Hit differs from the candidate: the candidate becomes the new hit and the counter becomes 1.
    - No hit: clear the counter and NOTE_VALID.
    - When the counter reaches STABLE_COUNT, NOTE is set to the candidate and NOTE_VALID to 1.
    - Then return to IDLE.
- Timeout: when the counter reaches MAX_HALF, clear NOTE_VALID and the match counter, and disarm. This happens in any state; a scan in progress is aborted to IDLE.
- Edges during SCAN/DECIDE still restart the counter and update HALF_PERIOD. A glitch capture during SCAN/DECIDE is dropped.
- ENABLE low clears the same state as reset, except the synchronizer.

## Timing
- Cycle E is the cycle in which the edge pulse is high. TONE_IN transition to E is SYNC_STAGES+1 cycles.
- HALF_PERIOD and the capture register update at the end of cycle E.
- SCAN occupies E+1..E+12; DECIDE is E+13. NOTE and NOTE_VALID are visible from E+14.
- NOTE_STROBE is high for exactly cycle E+14 when it fires.
- NOTE_VALID falls on the cycle after a timeout, glitch or no-hit decision.
- RESET_N low at any time, including mid-SCAN, forces all outputs to reset values immediately. The first edge after reset only arms.

## Structure
- Package tone_pkg:
  - note index enum;
  - NOM table;
  - the generator constants, so the generator can import the same values;
  - tolerance shift constant, 6.
- Sub-module tone_edge_sync: the synchronizer and both-edge detector, parameterised by SYNC_STAGES.
- The counter, capture, FSM and stability logic live in tone_detector.

## Test plan
- Square wave with 56819-cycle half-periods, 5 edges → NOTE=0, NOTE_VALID=1 at E5+14, and exactly one NOTE_STROBE.
- Half-period 57700 → matches A. Half-period 57800 → no hit, and NOTE_VALID stays 0.
- A locked, then switch to 95420 → NOTE_VALID drops at the first C decision. After 4 C half-periods, NOTE=3 and NOTE_STROBE pulses.
- A locked, then a 10-cycle glitch pulse → NOTE_VALID=0 next cycle. Re-locks after 4 further clean half-periods.
- A locked, then TONE_IN held constant → NOTE_VALID falls 200000 cycles after the last edge. HALF_PERIOD keeps its last value.
- RESET_N pulsed low during SCAN → all outputs 0 immediately. The first following edge produces no capture.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared constants for the square-wave tone generator and tone_detector:
// note indices, generator half-period constants and nominal capture table.
package tone_pkg;

    localparam int HALF_W    = 18;
    localparam int NUM_NOTES = 12;
    localparam int TOL_SHIFT = 6;

    typedef enum logic [3:0] {
        NOTE_A  = 4'd0,
        NOTE_AS = 4'd1,
        NOTE_B  = 4'd2,
        NOTE_C  = 4'd3,
        NOTE_CS = 4'd4,
        NOTE_D  = 4'd5,
        NOTE_DS = 4'd6,
        NOTE_E  = 4'd7,
        NOTE_F  = 4'd8,
        NOTE_FS = 4'd9,
        NOTE_G  = 4'd10,
        NOTE_GS = 4'd11
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DECIDE
    } det_state_e;

    // The generator toggles its pin every GEN_CONST+1 cycles, hence NOM = GEN_CONST + 1.
    localparam logic [HALF_W-1:0] GEN_CONST [NUM_NOTES] = '{
        18'd56818, 18'd53658, 18'd50607, 18'd95419, 18'd91911, 18'd85034,
        18'd80385, 18'd75757, 18'd71632, 18'd67567, 18'd63755, 18'd60240
    };

    localparam logic [HALF_W-1:0] NOM [NUM_NOTES] = '{
        18'd56819, 18'd53659, 18'd50608, 18'd95420, 18'd91912, 18'd85035,
        18'd80386, 18'd75758, 18'd71633, 18'd67568, 18'd63756, 18'd60241
    };

    function automatic logic [HALF_W-1:0] nom_half(input logic [3:0] idx);
        nom_half = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (idx == 4'(i)) nom_half = NOM[i];
        end
    endfunction

    function automatic logic in_window(input logic [HALF_W-1:0] cap,
                                       input logic [HALF_W-1:0] nom);
        logic [HALF_W-1:0] diff;
        diff = (cap >= nom) ? (cap - nom) : (nom - cap);
        return diff <= (nom >> TOL_SHIFT);
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Multi-flop synchronizer for the asynchronous tone input followed by a
// registered both-edge detector producing a one-cycle edge pulse.
module tone_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_q;
    logic                   edge_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour and the chain shifts one stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            level_q <= sync_q[SYNC_STAGES-1];
            edge_q  <= sync_q[SYNC_STAGES-1] ^ level_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the half-period of a square wave and decodes it to a chromatic
// note index with a table-scan FSM and a consecutive-match stability filter.
module tone_detector
    import tone_pkg::*;
#(
    parameter int MAX_HALF     = 200000,
    parameter int MIN_HALF     = 20000,
    parameter int STABLE_COUNT = 4,
    parameter int SYNC_STAGES  = 2,
    // Divides the nominal table by 2**TABLE_SHIFT for a proportionally slower clock.
    parameter int TABLE_SHIFT  = 0
) (
    input  logic              CLK_50,
    input  logic              RESET_N,
    input  logic              TONE_IN,
    input  logic              ENABLE,
    output logic [3:0]        NOTE,
    output logic              NOTE_VALID,
    output logic              NOTE_STROBE,
    output logic [HALF_W-1:0] HALF_PERIOD
);

    localparam logic [HALF_W-1:0] MAX_V    = HALF_W'(MAX_HALF);
    localparam logic [HALF_W-1:0] MIN_V    = HALF_W'(MIN_HALF);
    localparam logic [3:0]        STABLE_V = 4'(STABLE_COUNT);
    localparam logic [3:0]        LAST_IDX = 4'(NUM_NOTES - 1);

    logic edge_w;

    tone_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i (CLK_50),
        .rst_ni(RESET_N),
        .d_i   (TONE_IN),
        .edge_o(edge_w)
    );

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              armed_q, armed_d;
    logic [HALF_W-1:0] hp_q, hp_d;
    logic [HALF_W-1:0] scan_val_q, scan_val_d;
    det_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              hit_q, hit_d;
    note_e             hit_idx_q, hit_idx_d;
    note_e             cand_q, cand_d;
    logic [3:0]        mcnt_q, mcnt_d;
    note_e             note_q, note_d;
    logic              valid_q, valid_d;
    logic              strobe_q, strobe_d;

    logic              timeout;
    logic              capture;
    logic              glitch;
    logic              scan_hit;

    assign timeout  = (cnt_q == MAX_V);
    assign capture  = edge_w && armed_q && !timeout;
    assign glitch   = capture && (cnt_q < MIN_V);
    assign scan_hit = in_window(scan_val_q, nom_half(idx_q) >> TABLE_SHIFT);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        cnt_d      = cnt_q;
        armed_d    = armed_q;
        hp_d       = hp_q;
        scan_val_d = scan_val_q;
        state_d    = state_q;
        idx_d      = idx_q;
        hit_d      = hit_q;
        hit_idx_d  = hit_idx_q;
        cand_d     = cand_q;
        mcnt_d     = mcnt_q;
        note_d     = note_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;

        if (edge_w) begin
            cnt_d   = HALF_W'(1);
            armed_d = 1'b1;
        end else if (!timeout) begin
            cnt_d = cnt_q + HALF_W'(1);
        end else begin
            armed_d = 1'b0;
        end

        if (capture) hp_d = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (glitch) begin
                    mcnt_d  = 4'd0;
                    valid_d = 1'b0;
                end else if (capture) begin
                    scan_val_d = cnt_q;
                    idx_d      = 4'd0;
                    hit_d      = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!hit_q && scan_hit) begin
                    hit_d     = 1'b1;
                    hit_idx_d = note_e'(idx_q);
                end
                if (idx_q == LAST_IDX) state_d = ST_DECIDE;
                else                   idx_d   = idx_q + 4'd1;
            end
            ST_DECIDE: begin
                state_d = ST_IDLE;
                if (!hit_q) begin
                    mcnt_d  = 4'd0;
                    valid_d = 1'b0;
                end else begin
                    if (hit_idx_q == cand_q) begin
                        mcnt_d = (mcnt_q >= STABLE_V) ? STABLE_V : mcnt_q + 4'd1;
                    end else begin
                        cand_d = hit_idx_q;
                        mcnt_d = 4'd1;
                    end
                    if (mcnt_d == STABLE_V) begin
                        note_d   = cand_d;
                        valid_d  = 1'b1;
                        strobe_d = !valid_q || (note_q != cand_d);
                    end else begin
                        valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Silence aborts whatever the FSM was doing.
        if (timeout) begin
            valid_d  = 1'b0;
            mcnt_d   = 4'd0;
            strobe_d = 1'b0;
            state_d  = ST_IDLE;
        end

        if (!ENABLE) begin
            cnt_d      = '0;
            armed_d    = 1'b0;
            hp_d       = '0;
            scan_val_d = '0;
            state_d    = ST_IDLE;
            idx_d      = 4'd0;
            hit_d      = 1'b0;
            hit_idx_d  = NOTE_A;
            cand_d     = NOTE_A;
            mcnt_d     = 4'd0;
            note_d     = NOTE_A;
            valid_d    = 1'b0;
            strobe_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q      <= '0;
            armed_q    <= 1'b0;
            hp_q       <= '0;
            scan_val_q <= '0;
            state_q    <= ST_IDLE;
            idx_q      <= 4'd0;
            hit_q      <= 1'b0;
            hit_idx_q  <= NOTE_A;
            cand_q     <= NOTE_A;
            mcnt_q     <= 4'd0;
            note_q     <= NOTE_A;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            armed_q    <= armed_d;
            hp_q       <= hp_d;
            scan_val_q <= scan_val_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            hit_q      <= hit_d;
            hit_idx_q  <= hit_idx_d;
            cand_q     <= cand_d;
            mcnt_q     <= mcnt_d;
            note_q     <= note_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
        end
    end

    assign NOTE        = note_q;
    assign NOTE_VALID  = valid_q;
    assign NOTE_STROBE = strobe_q;
    assign HALF_PERIOD = hp_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector with the table scaled by 2**5 so each
// half-period is short: A=1775 (window +-27), C=2981, MIN=625, MAX=6250.
module tb_tone_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tone;
    logic        en;
    logic [3:0]  note;
    logic        valid;
    logic        strobe;
    logic [17:0] hp;

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;
    int since      = 0;

    localparam int A_H   = 1775;  // 56819 >> 5
    localparam int C_H   = 2981;  // 95420 >> 5
    localparam int A_HI  = 1802;  // A + 27, inside window
    localparam int A_LO  = 1748;  // A - 27, inside window
    localparam int A_OUT = 1803;  // A + 28, no table entry
    localparam int TMO   = 6250;

    always #5 clk = ~clk;

    tone_detector #(
        .MAX_HALF    (TMO),
        .MIN_HALF    (625),
        .STABLE_COUNT(4),
        .SYNC_STAGES (2),
        .TABLE_SHIFT (5)
    ) dut (
        .CLK_50     (clk),
        .RESET_N    (rst_n),
        .TONE_IN    (tone),
        .ENABLE     (en),
        .NOTE       (note),
        .NOTE_VALID (valid),
        .NOTE_STROBE(strobe),
        .HALF_PERIOD(hp)
    );

    always @(posedge clk) if (strobe === 1'b1) strobe_cnt++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            since++;
        end
    endtask

    task automatic wait_until(input int t);
        step(t - since);
    endtask

    // Toggle in cycle k gives the edge pulse in cycle E = k+3.
    task automatic flip();
        tone  = ~tone;
        since = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        tone  = 1'b0;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        step(3);
        check("rst_note",   32'(note),   0);
        check("rst_valid",  32'(valid),  0);
        check("rst_strobe", 32'(strobe), 0);
        check("rst_hp",     32'(hp),     0);
        rst_n = 1'b1;
        step(4);

        // Lock A: 5 edges, first arms, 4 captures.
        flip();
        repeat (4) begin wait_until(A_H); flip(); end
        wait_until(16);
        check("a_pre_valid", 32'(valid), 0);
        check("a_hp",        32'(hp),    A_H);
        wait_until(17);
        check("a_valid",  32'(valid),  1);
        check("a_note",   32'(note),   0);
        check("a_strobe", 32'(strobe), 1);
        wait_until(18);
        check("a_strobe_end",  32'(strobe), 0);
        check("a_strobe_once", 32'(strobe_cnt), 1);

        // Window edges keep the lock without another strobe.
        wait_until(A_HI); flip(); wait_until(17);
        check("a_hi_valid", 32'(valid), 1);
        check("a_hi_hp",    32'(hp),    A_HI);
        wait_until(A_LO); flip(); wait_until(17);
        check("a_lo_valid",   32'(valid),      1);
        check("a_lo_hp",      32'(hp),         A_LO);
        check("a_no_restrobe", 32'(strobe_cnt), 1);

        // Just outside the window: no hit.
        wait_until(A_OUT); flip(); wait_until(16);
        check("nohit_before", 32'(valid), 1);
        wait_until(17);
        check("nohit_drop", 32'(valid), 0);
        repeat (3) begin wait_until(A_OUT); flip(); end
        wait_until(17);
        check("nohit_stays", 32'(valid), 0);
        check("nohit_hp",    32'(hp),    A_OUT);

        repeat (4) begin wait_until(A_H); flip(); end
        wait_until(17);
        check("relock_valid",  32'(valid),  1);
        check("relock_strobe", 32'(strobe), 1);

        // Switch A -> C.
        wait_until(C_H); flip(); wait_until(16);
        check("c1_before", 32'(valid), 1);
        wait_until(17);
        check("c1_drop", 32'(valid), 0);
        repeat (3) begin wait_until(C_H); flip(); end
        wait_until(16);
        check("c4_before", 32'(valid), 0);
        wait_until(17);
        check("c_note",   32'(note),   3);
        check("c_valid",  32'(valid),  1);
        check("c_strobe", 32'(strobe), 1);

        // Back to A, then a 10-cycle glitch pulse 500 cycles after an edge.
        repeat (4) begin wait_until(A_H); flip(); end
        wait_until(17);
        check("g_lock_note",  32'(note),  0);
        check("g_lock_valid", 32'(valid), 1);
        wait_until(500); flip();
        wait_until(3);
        check("g_edge_cycle", 32'(valid), 1);
        wait_until(4);
        check("g_drop", 32'(valid), 0);
        check("g_hp",   32'(hp),    500);
        wait_until(10); flip();
        wait_until(4);
        check("g2_hp",    32'(hp),    10);
        check("g2_valid", 32'(valid), 0);
        wait_until(A_H - 510); flip();
        repeat (3) begin wait_until(A_H); flip(); end
        wait_until(A_H); flip();
        wait_until(16);
        check("g_relock_before", 32'(valid), 0);
        wait_until(17);
        check("g_relock_valid",  32'(valid),  1);
        check("g_relock_note",   32'(note),   0);
        check("g_relock_strobe", 32'(strobe), 1);

        // Silence: timeout at E+MAX, valid falls one cycle later.
        wait_until(3 + TMO);
        check("pre_timeout", 32'(valid), 1);
        wait_until(3 + TMO + 1);
        check("timeout_drop", 32'(valid), 0);
        check("timeout_hp",   32'(hp),    A_H);
        flip(); wait_until(20);
        check("tmo_arm_only", 32'(hp), A_H);
        wait_until(1700); flip(); wait_until(4);
        check("tmo_capture", 32'(hp), 1700);

        // Lock C, then reset in the middle of a scan.
        repeat (4) begin wait_until(C_H); flip(); end
        wait_until(17);
        check("r_lock_note",  32'(note),  3);
        check("r_lock_valid", 32'(valid), 1);
        wait_until(C_H); flip(); wait_until(8);
        rst_n = 1'b0;
        #1;
        check("r_note",   32'(note),   0);
        check("r_valid",  32'(valid),  0);
        check("r_strobe", 32'(strobe), 0);
        check("r_hp",     32'(hp),     0);
        tone = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(5);
        flip(); wait_until(20);
        check("r_arm_only", 32'(hp), 0);
        wait_until(C_H); flip(); wait_until(4);
        check("r_capture", 32'(hp), C_H);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
